mmio_responder: RTL
===================

Name: mmio_responder

Overview:
- Memory-mapped I/O target on the core's data-memory port; the responder side of the load/store traffic the pipeline issues.
- Decodes stage-2 load/store requests to the MMIO region and returns read data with 1-cycle latency, aligned with stage-3 writeback, like the data BRAM.
- Owns the UART ready/valid handshakes, a one-entry TX holding buffer, and the cycle and retired-instruction counters.

Parameters:
- MMIO_TOP, 4'h8: value of addr[31:28] that selects MMIO.
- CNT_WIDTH, 32: width of both counters (wraps modulo 2^CNT_WIDTH).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_addr  in  32  stage-2 ALU address
- req_wdata  in  32  store data, already forwarded
- req_we  in  4  store byte enables; any nonzero bit = write
- req_re  in  1  load in stage 2
- inst_retired  in  1  pulse: non-bubble instruction in stage 3
- resp_rdata  out  32  registered read data, valid in the cycle after the request
- resp_hit  out  1  registered; 1 when resp_rdata is MMIO data (selects the wb source over mem)
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  received byte available
- uart_rx_ready  out  1  consume received byte
- uart_tx_data  out  8  byte to transmit
- uart_tx_valid  out  1  tx_data valid
- uart_tx_ready  in  1  transmitter accepts byte

Behaviour:
- Address decode:
  - sel = (req_addr[31:28] == MMIO_TOP).
  - Offset = req_addr[7:0].
  - Other address bits are ignored.
- Register map:
  - 0x00 CTRL: R = {29'b0, tx_ovf, rx_valid, tx_empty}. W: wdata[2]=1 clears tx_ovf.
  - 0x04 RX: R = {24'b0, uart_rx_data}. Pulses uart_rx_ready combinationally in the request cycle: rx_ready = sel & req_re & offset==0x04. The read returns uart_rx_data as sampled at that edge. Returns the byte even if rx_valid=0 (software polls CTRL).
  - 0x08 TX: W loads wdata[7:0] into the buffer. R = 0.
  - 0x10 CYCLES: R = cycle counter.
  - 0x14 INSTRET: R = instret counter.
  - 0x18 CNT_RST: any write zeroes both counters. R = 0.
  - Unmapped offsets: reads return 0, writes are ignored. Writes to read-only registers are ignored.
- Read timing:
  - At the request edge: resp_rdata <= selected value, resp_hit <= sel & req_re.
  - Non-MMIO or no read: resp_hit <= 0, resp_rdata <= 0.
  - A read captures the pre-update value of any register written or counted in the same cycle.
- TX buffer FSM:
  - States: EMPTY, FULL. uart_tx_valid = (state == FULL); tx_empty = (state == EMPTY).
  - EMPTY, write 0x08 -> FULL, latch byte.
  - FULL, uart_tx_ready -> EMPTY.
  - FULL with handshake and new write in the same cycle -> stays FULL with the new byte, no overflow.
  - FULL, write without handshake -> byte dropped, tx_ovf <= 1 (sticky).
  - A clear of tx_ovf and a new overflow in the same cycle: the set wins.
- Counters:
  - cycle increments every cycle; instret increments when inst_retired=1.
  - A CNT_RST write in the same cycle forces both to 0, suppressing that cycle's increment.
  - Wrap from all-ones to 0 silently.
- Reset, in any state, including mid-handshake:
  - resp_rdata=0, resp_hit=0.
  - TX state EMPTY, tx_ovf=0; any pending byte is lost.
  - uart_tx_data=0.
  - Both counters 0.
  - uart_rx_ready is held 0 while rst is asserted.
- Simultaneous req_re and nonzero req_we: the write takes effect and the read returns the pre-write value.

Decomposition:
- Shared package/header mmio_defs.vh:
  - offsets MMIO_CTRL, MMIO_RX, MMIO_TX, MMIO_CYCLES, MMIO_INSTRET, MMIO_CNT_RST;
  - CTRL bit indices;
  - TX state encodings.
- One natural sub-module: mmio_tx_buffer (the 2-state holding buffer with overflow flag).
- Counters and decode stay in the top level.

Test Plan:
- Counters: rst for 2 cycles, release, idle 10 cycles, then load 0x80000010 -> resp_rdata=10 next cycle, resp_hit=1. Load 0x80000014 with inst_retired held 0 -> 0.
- Pulse inst_retired 5 times; store to 0x80000018 in the same cycle as a 6th pulse -> INSTRET read next cycle = 0 and CYCLES read next cycle = 0. A counter read issued in the store cycle returns the pre-reset value.
- TX hold: uart_tx_ready=0; store 0x41 to 0x80000008 -> tx_valid=1, tx_data=0x41, CTRL read=0. Second store 0x42 -> CTRL read=0x4, tx_data still 0x41. Raise tx_ready 1 cycle -> tx_valid=0, CTRL=0x5. Store 0x4 to CTRL -> CTRL=0x1.
- TX replace: buffer FULL, assert tx_ready and store 0x55 to TX in the same cycle -> FULL with 0x55, tx_ovf stays 0.
- RX: uart_rx_valid=1, rx_data=0xA5; load CTRL -> 0x3. Load 0x80000004 -> rx_ready high exactly that cycle, resp_rdata=0x000000A5 next cycle.
- Non-MMIO load of 0x10000010 -> resp_hit=0, resp_rdata=0, no rx_ready. Assert rst while TX is FULL -> tx_valid=0 on the next edge.

Source files
------------

// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: register offsets, CTRL bits, TX states.
package mmio_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 8;
  localparam int unsigned BYTE_W = 8;

  localparam logic [3:0]  MMIO_TOP_DEFAULT  = 4'h8;
  localparam int unsigned CNT_WIDTH_DEFAULT = 32;

  // Register offsets within the MMIO window (addr[7:0])
  localparam logic [OFF_W-1:0] MMIO_CTRL    = 8'h00;
  localparam logic [OFF_W-1:0] MMIO_RX      = 8'h04;
  localparam logic [OFF_W-1:0] MMIO_TX      = 8'h08;
  localparam logic [OFF_W-1:0] MMIO_CYCLES  = 8'h10;
  localparam logic [OFF_W-1:0] MMIO_INSTRET = 8'h14;
  localparam logic [OFF_W-1:0] MMIO_CNT_RST = 8'h18;

  // CTRL register bit positions
  localparam int unsigned CTRL_TX_EMPTY = 0;
  localparam int unsigned CTRL_RX_VALID = 1;
  localparam int unsigned CTRL_TX_OVF   = 2;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/mmio_tx_buffer.sv
// One-entry UART TX holding buffer with a sticky overflow flag.
module mmio_tx_buffer
  import mmio_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              ovf_clr_i,
  input  logic              tx_ready_i,
  output logic              tx_valid_o,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              empty_o,
  output logic              ovf_o
);

  tx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              ovf_q, ovf_d;

  // State, byte and overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: a new overflow in the same cycle as a clear leaves the flag set
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    case (state_q)
      TX_EMPTY: begin
        if (wr_i) begin
          state_d = TX_FULL;
          data_d  = wdata_i;
        end
      end
      TX_FULL: begin
        if (tx_ready_i) begin
          if (wr_i) begin
            data_d = wdata_i;
          end else begin
            state_d = TX_EMPTY;
          end
        end else if (wr_i) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = TX_EMPTY;
    endcase
  end

  assign tx_valid_o = (state_q == TX_FULL);
  assign empty_o    = (state_q == TX_EMPTY);
  assign tx_data_o  = data_q;
  assign ovf_o      = ovf_q;

endmodule

// File: rtl/mmio_responder.sv
// MMIO target on the data-memory port: UART handshakes, TX buffer, cycle/instret counters.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [3:0]  MMIO_TOP  = MMIO_TOP_DEFAULT,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_we,
  input  logic              req_re,
  input  logic              inst_retired,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  input  logic [BYTE_W-1:0] uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ready,
  output logic [BYTE_W-1:0] uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready
);

  logic             sel_c;
  logic [OFF_W-1:0] off_c;
  logic             rd_c;
  logic             wr_c;
  logic             tx_wr_c;
  logic             ovf_clr_c;
  logic             cnt_rst_c;
  logic             tx_empty;
  logic             tx_ovf;
  logic [DATA_W-1:0] rdata_c;

  logic [DATA_W-1:0]    resp_rdata_q, resp_rdata_d;
  logic                 resp_hit_q, resp_hit_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  logic unused_bits;
  assign unused_bits = ^{req_addr[27:8], req_wdata[31:8]};

  // Address decode and write strobes
  always_comb begin
    sel_c     = (req_addr[31:28] == MMIO_TOP);
    off_c     = req_addr[OFF_W-1:0];
    rd_c      = sel_c & req_re;
    wr_c      = sel_c & (|req_we);
    tx_wr_c   = wr_c & (off_c == MMIO_TX);
    ovf_clr_c = wr_c & (off_c == MMIO_CTRL) & req_wdata[CTRL_TX_OVF];
    cnt_rst_c = wr_c & (off_c == MMIO_CNT_RST);
  end

  // RX byte is consumed in the cycle the load is presented
  assign uart_rx_ready = ~rst & rd_c & (off_c == MMIO_RX);

  // Read mux over current (pre-update) register values
  always_comb begin
    rdata_c = '0;
    case (off_c)
      MMIO_CTRL: begin
        rdata_c[CTRL_TX_EMPTY] = tx_empty;
        rdata_c[CTRL_RX_VALID] = uart_rx_valid;
        rdata_c[CTRL_TX_OVF]   = tx_ovf;
      end
      MMIO_RX:      rdata_c = DATA_W'(uart_rx_data);
      MMIO_CYCLES:  rdata_c = DATA_W'(cycle_q);
      MMIO_INSTRET: rdata_c = DATA_W'(instret_q);
      default:      rdata_c = '0;
    endcase
  end

  // Response and counter next-state; a counter reset overrides the increment
  always_comb begin
    resp_hit_d   = rd_c;
    resp_rdata_d = rd_c ? rdata_c : '0;
    cycle_d      = cycle_q + CNT_WIDTH'(1);
    instret_d    = instret_q + (inst_retired ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
    if (cnt_rst_c) begin
      cycle_d   = '0;
      instret_d = '0;
    end
  end

  // Response and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata_q <= '0;
      resp_hit_q   <= 1'b0;
      cycle_q      <= '0;
      instret_q    <= '0;
    end else begin
      resp_rdata_q <= resp_rdata_d;
      resp_hit_q   <= resp_hit_d;
      cycle_q      <= cycle_d;
      instret_q    <= instret_d;
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_hit   = resp_hit_q;

  mmio_tx_buffer u_tx_buffer (
    .clk        (clk),
    .rst        (rst),
    .wr_i       (tx_wr_c),
    .wdata_i    (req_wdata[BYTE_W-1:0]),
    .ovf_clr_i  (ovf_clr_c),
    .tx_ready_i (uart_tx_ready),
    .tx_valid_o (uart_tx_valid),
    .tx_data_o  (uart_tx_data),
    .empty_o    (tx_empty),
    .ovf_o      (tx_ovf)
  );

endmodule
